// File: rtl/amm_frame_pkg.sv
// Shared constants and response type for the Avalon-MM frame/image memory slave.
// Region map of the SDRAM window this slave stands in for.
package amm_frame_pkg;

  localparam int unsigned RESP_DATA_W = 32;

  localparam logic [31:0] BAD_READ_DATA      = 32'hBAD1_BAD1;

  localparam logic [31:0] VGA_START_ADDR     = 32'h0100_0000;
  localparam logic [31:0] VGA_END_ADDR       = 32'h0104_AFFF;
  localparam logic [31:0] INP_IMG_START_ADDR = 32'h0105_0000;
  localparam logic [31:0] INP_IMG_END_ADDR   = 32'h0105_FFFF;
  localparam logic [31:0] START_BYTE_ADDR    = 32'h0106_0000;

  localparam logic [31:0] START_BYTE         = 32'hF00B_F00B;
  localparam logic [31:0] STOP_BYTE          = 32'hDEAD_F00B;

  typedef struct packed {
    logic                   valid;
    logic [RESP_DATA_W-1:0] data;
  } amm_resp_t;

endpackage

// File: rtl/amm_frame_slave_if.sv
// Avalon-MM slave bus bundle (burst-less, single-word) between fabric master and frame memory.
interface amm_frame_slave_if #(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32
);

  logic [ADDRESSWIDTH-1:0]  slave_address;
  logic [DATAWIDTH/8-1:0]   slave_byteenable;
  logic [DATAWIDTH-1:0]     slave_writedata;
  logic                     slave_write;
  logic                     slave_read;
  logic                     slave_waitrequest;
  logic [DATAWIDTH-1:0]     slave_readdata;
  logic                     slave_readdatavalid;

  modport master (
    output slave_address, slave_byteenable, slave_writedata, slave_write, slave_read,
    input  slave_waitrequest, slave_readdata, slave_readdatavalid
  );

  modport slave (
    input  slave_address, slave_byteenable, slave_writedata, slave_write, slave_read,
    output slave_waitrequest, slave_readdata, slave_readdatavalid
  );

endinterface

// File: rtl/amm_read_pipe.sv
// Fixed-latency read response pipe: LATENCY valid/data stages with synchronous flush.
// Data only moves with a valid token, so the last stage holds the most recent response.
module amm_read_pipe
  import amm_frame_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic      clk,
  input  logic      flush,
  input  amm_resp_t in_resp,
  output amm_resp_t out_resp
);

  amm_resp_t stage [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_resp.valid;
      if (in_resp.valid) stage[0].data <= in_resp.data;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i].valid <= stage[i-1].valid;
        if (stage[i-1].valid) stage[i].data <= stage[i-1].data;
      end
    end
  end

  assign out_resp = stage[LATENCY-1];

endmodule

// File: rtl/amm_frame_slave.sv
// Avalon-MM slave modelling the VGA frame / input image memory: byte-enabled writes,
// fixed-latency pipelined reads with capped outstanding count, backpressure and error reporting.
module amm_frame_slave
  import amm_frame_pkg::*;
#(
  parameter int                    ADDRESSWIDTH = 26,
  parameter int                    DATAWIDTH    = 32,
  parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR  = 26'h1000000,
  parameter int                    MEM_WORDS    = 1024,
  parameter int                    READ_LATENCY = 2,
  parameter int                    MAX_PENDING  = 2,
  localparam int                   PEND_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  amm_frame_slave_if.slave    bus,
  input  logic                stall_en,
  output logic [PEND_W-1:0]   pending_count,
  output logic [15:0]         oor_count,
  output logic                proto_err
);

  localparam int                      LANES     = DATAWIDTH / 8;
  localparam int                      IDX_W     = $clog2(MEM_WORDS);
  localparam logic [ADDRESSWIDTH-1:0] MEM_BYTES = ADDRESSWIDTH'(MEM_WORDS * 4);
  localparam logic [PEND_W-1:0]       PEND_MAX  = PEND_W'(MAX_PENDING);

  logic [DATAWIDTH-1:0]    mem [MEM_WORDS];
  logic [ADDRESSWIDTH-1:0] offset;
  logic [IDX_W-1:0]        word_idx;
  logic                    in_range;
  logic                    read_req;
  logic                    read_accept;
  logic                    write_accept;
  amm_resp_t               pipe_in;
  amm_resp_t               pipe_out;

  // Offset wraps at the bus width, so addresses below the base land far out of range.
  assign offset   = bus.slave_address - BASE_ADDR;
  assign in_range = offset < MEM_BYTES;
  assign word_idx = offset[IDX_W+1:2];

  // A read alongside a write is a protocol error and is dropped; the write wins.
  assign read_req = bus.slave_read & ~bus.slave_write;

  // A full pipe can still take a read when a response leaves in the same cycle.
  assign bus.slave_waitrequest = stall_en
                               | (read_req & (pending_count == PEND_MAX) & ~pipe_out.valid);

  assign write_accept = bus.slave_write & ~bus.slave_waitrequest;
  assign read_accept  = read_req & ~bus.slave_waitrequest;

  // NOTE: the memory array is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (reset_n && write_accept && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.slave_byteenable[i]) mem[word_idx][i*8 +: 8] <= bus.slave_writedata[i*8 +: 8];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pipe_in = '0;
    if (read_accept) begin
      pipe_in.valid = 1'b1;
      pipe_in.data  = in_range ? mem[word_idx] : BAD_READ_DATA;
    end
  end

  amm_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk      (clk),
    .flush    (~reset_n),
    .in_resp  (pipe_in),
    .out_resp (pipe_out)
  );

  assign bus.slave_readdatavalid = pipe_out.valid;
  assign bus.slave_readdata      = pipe_out.data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_count <= '0;
      oor_count     <= '0;
      proto_err     <= 1'b0;
    end else begin
      case ({read_accept, pipe_out.valid})
        2'b10:   pending_count <= pending_count + PEND_W'(1);
        2'b01:   pending_count <= pending_count - PEND_W'(1);
        default: pending_count <= pending_count;
      endcase
      if ((read_accept || write_accept) && !in_range && (oor_count != 16'hFFFF)) begin
        oor_count <= oor_count + 16'd1;
      end
      if (bus.slave_read && bus.slave_write) proto_err <= 1'b1;
    end
  end

endmodule
